// File: rtl/aes_inv_round_core.sv
// AES decrypt round datapath without InvSubBytes.
// Two-stage valid/ready pipe: InvShiftRows+AddRoundKey, then optional InvMixColumns.
module aes_inv_round_core (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] block,
    input  logic [127:0] round_key,
    input  logic         last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] new_block
);

    logic         s1_valid_q, s1_valid_d;
    logic         s1_last_q, s1_last_d;
    logic [127:0] s1_data_q, s1_data_d;
    logic         s2_valid_q, s2_valid_d;
    logic [127:0] s2_data_q, s2_data_d;
    logic         s2_adv;
    logic         s1_acc;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Row r of the state rotates right by r byte positions
    function automatic logic [127:0] inv_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a  [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31-8*i -: 8];
            x2    = xt(a[i]);
            x4    = xt(x2);
            x8    = xt(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            o[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
        end
        return o;
    endfunction

    assign s2_adv    = s1_valid_q & (~s2_valid_q | out_ready);
    assign in_ready  = ~s1_valid_q | s2_adv;
    assign s1_acc    = in_valid & in_ready;
    assign out_valid = s2_valid_q;
    assign new_block = s2_data_q;

    always_comb begin
        s1_valid_d = s1_acc | (s1_valid_q & ~s2_adv);
        s1_data_d  = s1_data_q;
        s1_last_d  = s1_last_q;
        s2_valid_d = s2_adv | (s2_valid_q & ~out_ready);
        s2_data_d  = s2_data_q;
        if (s1_acc) begin
            s1_data_d = inv_shift(block) ^ round_key;
            s1_last_d = last;
        end
        if (s2_adv) begin
            s2_data_d = s1_last_q ? s1_data_q : inv_mix(s1_data_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_data_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_last_q  <= s1_last_d;
            s1_data_q  <= s1_data_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
        end
    end

endmodule
